if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//   Sequencer for the instruction-fetch stage: owns the PC, issues one instruction-memory
//   request at a time over a req/gnt/rvalid handshake, and presents fetched words to IF/ID.
//   Applies hazard-unit stalls and ID-stage branch/jump redirects.
//   Kills in-flight fetches on redirect and raises IF_flush toward IF/ID.
//   Sits between the hazard/branch logic and the instruction ROM/cache port.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address
//   NOP_WORD  32'h0000_0000  value driven on instr_o when no valid instruction is held
// PORTS
//   clk            in   1   clock, all state on rising edge
//   reset          in   1   synchronous, active-high
//   stall_i        in   1   hazard unit: hold presented instruction (IFWrite = ~stall_i)
//   redirect_i     in   1   branch taken or jump in ID; 1-cycle pulse
//   redirect_pc_i  in   32  target address; bits [1:0] ignored (forced 00)
//   imem_req_o     out  1   fetch request
//   imem_addr_o    out  32  fetch address; word aligned
//   imem_gnt_i     in   1   memory accepted request this cycle (req & gnt = handshake)
//   imem_rvalid_i  in   1   read data valid; exactly one per granted request, >=1 cycle after gnt
//   imem_rdata_i   in   32  instruction word
//   instr_o        out  32  instruction presented to IF/ID
//   pc_o           out  32  address of instr_o
//   instr_valid_o  out  1   instr_o/pc_o valid
//   if_flush_o     out  1   flush IF/ID (bubble)
// BEHAVIOUR
//   Reset: state=REQ_S (entered on first cycle after reset deasserts), pc=RESET_PC,
//     imem_req_o=0, instr_valid_o=0, instr_o=NOP_WORD, pc_o=RESET_PC, kill=0,
//     if_flush_o=1 while reset is high.
//   Reset mid-operation: abort everything; any later rvalid for the old request is ignored.
//   FSM (one outstanding request max):
//     REQ_S : imem_req_o=1, imem_addr_o=pc. gnt -> WAIT_S. Else stay.
//             Redirect without gnt: pc<=target; addr changes next cycle; stay.
//             Redirect with gnt: kill<=1; go WAIT_S; pc<=target.
//     WAIT_S: req=0. On rvalid:
//               - kill=0 and no redirect: instr_o<=rdata, pc_o<=pc, go HOLD_S.
//               - kill=1 or redirect this cycle: drop word, kill<=0, go REQ_S.
//             Redirect while waiting (no rvalid): pc<=target, kill<=1, stay.
//     HOLD_S: instr_valid_o=1. stall_i=1 -> hold instr_o/pc_o unchanged.
//             stall_i=0 -> consumed; pc<=pc+4; instr_valid_o<=0; go REQ_S.
//             Redirect: drop held word; pc<=target; go REQ_S. Redirect beats stall.
//   if_flush_o: registered 1-cycle pulse in the cycle after any redirect_i.
//   instr_valid_o: 1 only in HOLD_S; instr_o returns to NOP_WORD when not valid.
//   PC arithmetic: 32-bit unsigned, pc+4 wraps 32'hFFFF_FFFC -> 32'h0.
//   Latency: 1-cycle memory gives rvalid T+1 after gnt at T; instr_valid_o at T+2.
//     Throughput is 1 instruction per 3 cycles; pipelined fetch is out of scope.
//   rvalid in REQ_S/HOLD_S is a protocol violation (assertion); ignored.
// STRUCTURE
//   cpu_pkg: fetch_state_t enum {REQ_S, WAIT_S, HOLD_S}; INSTR_W=32; PC_STEP=4; NOP constant.
//   Sub-module fetch_pc_reg: PC register plus next-PC mux {hold, +4, redirect target, reset}.
//   FSM, kill flag and output registers live in if_fetch_ctrl.
// TESTING
//   1) Reset, gnt=1, rvalid 1 cycle later, no stall -> addr 0x0,0x4,0x8.
//      instr_valid_o every 3rd cycle; pc_o matches.
//   2) stall_i high 4 cycles in HOLD_S with instr 0x8C01_0004 ->
//      instr_o/pc_o stable, imem_req_o=0, then next addr = pc+4.
//   3) redirect_i to 0x0000_0040 in WAIT_S, rvalid next cycle -> word dropped, if_flush_o pulse,
//      next request addr 0x40, no instr_valid_o for the killed word.
//   4) gnt held low 5 cycles in REQ_S, redirect to 0x100 at cycle 2 ->
//      addr switches to 0x100, req stays high; first valid pc_o=0x100.
//   5) redirect_i and stall_i together in HOLD_S -> redirect wins; fetch from target next cycle.
//   6) redirect_pc_i=0xFFFF_FFFE -> fetch 0xFFFF_FFFC, then 0x0000_0000 (wrap);
//      reset asserted in WAIT_S -> outputs at reset values, late rvalid ignored.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state encoding, the PC-mux select and the word-alignment helper.
package if_fetch_ctrl_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ_S  = 2'd0,
        WAIT_S = 2'd1,
        HOLD_S = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2
    } pc_sel_t;

    // Redirect targets may carry junk in the byte-offset bits.
    function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_chk.sv
// Protocol checker for the instruction-memory port: read data must answer a granted request.
// A request orphaned by reset stays pending, so its late rvalid is still legal.
module if_fetch_ctrl_chk (
    input logic clk,
    input logic reset,
    input logic i_req,
    input logic i_gnt,
    input logic i_rvalid
);

    logic r_pend;

    // Memory-side view of the outstanding request; deliberately survives reset.
    always_ff @(posedge clk) begin
        if (i_req && i_gnt) begin
            r_pend <= 1'b1;
        end else if (i_rvalid) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= r_pend;
        end
    end

    a_rvalid_needs_request: assert property (@(posedge clk) disable iff (reset)
        i_rvalid |-> r_pend);

endmodule

// File: rtl/if_fetch_ctrl_pc_reg.sv
// Program-counter register with next-PC selection: hold, sequential step, redirect target.
// Reset loads RESET_PC; the sequential step wraps naturally at 32 bits.
module if_fetch_ctrl_pc_reg
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  pc_sel_t            i_sel,
    input  logic [INSTR_W-1:0] i_target,
    output logic [INSTR_W-1:0] o_pc
);

    logic [INSTR_W-1:0] r_pc;
    logic [INSTR_W-1:0] w_pc_next;

    // Next-PC selection.
    always_comb begin
        w_pc_next = r_pc;
        case (i_sel)
            PC_HOLD:   w_pc_next = r_pc;
            PC_INC:    w_pc_next = r_pc + PC_STEP;
            PC_TARGET: w_pc_next = align_word(i_target);
            default:   w_pc_next = r_pc;
        endcase
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= align_word(RESET_PC);
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, stall/redirect handling,
// kill of in-flight fetches and an IF/ID flush pulse after every redirect.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [INSTR_W-1:0] redirect_pc_i,
    output logic               imem_req_o,
    output logic [INSTR_W-1:0] imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [INSTR_W-1:0] pc_o,
    output logic               instr_valid_o,
    output logic               if_flush_o
);

    fetch_state_t       r_state;
    fetch_state_t       w_next_state;
    logic               r_kill;
    logic               w_next_kill;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_next_instr;
    logic [INSTR_W-1:0] r_pc_o;
    logic [INSTR_W-1:0] w_next_pc_o;
    logic               r_valid;
    logic               w_next_valid;
    logic               r_flush;
    pc_sel_t            w_pc_sel;
    logic [INSTR_W-1:0] w_pc;
    logic               w_req;
    logic               w_hs;

    if_fetch_ctrl_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .i_sel    (w_pc_sel),
        .i_target (redirect_pc_i),
        .o_pc     (w_pc)
    );

    if_fetch_ctrl_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .i_req    (w_req),
        .i_gnt    (imem_gnt_i),
        .i_rvalid (imem_rvalid_i)
    );

    // Request is live from the first cycle after reset deasserts, never during reset.
    assign w_req = (r_state == REQ_S) && !reset;
    assign w_hs  = w_req && imem_gnt_i;

    // Next-state, kill flag, PC select and output-register next values.
    always_comb begin
        w_next_state = r_state;
        w_next_kill  = r_kill;
        w_pc_sel     = PC_HOLD;
        w_next_instr = r_instr;
        w_next_pc_o  = r_pc_o;
        w_next_valid = r_valid;
        case (r_state)
            REQ_S: begin
                if (w_hs) begin
                    w_next_state = WAIT_S;
                    if (redirect_i) begin
                        w_next_kill = 1'b1;
                        w_pc_sel    = PC_TARGET;
                    end else begin
                        w_next_kill = 1'b0;
                    end
                end else if (redirect_i) begin
                    w_pc_sel = PC_TARGET;
                end else begin
                    w_pc_sel = PC_HOLD;
                end
            end
            WAIT_S: begin
                if (imem_rvalid_i) begin
                    if (r_kill || redirect_i) begin
                        // Word belongs to a superseded fetch: drop it and refetch.
                        w_next_kill  = 1'b0;
                        w_next_state = REQ_S;
                        if (redirect_i) begin
                            w_pc_sel = PC_TARGET;
                        end else begin
                            w_pc_sel = PC_HOLD;
                        end
                    end else begin
                        w_next_instr = imem_rdata_i;
                        w_next_pc_o  = w_pc;
                        w_next_valid = 1'b1;
                        w_next_state = HOLD_S;
                    end
                end else if (redirect_i) begin
                    w_pc_sel    = PC_TARGET;
                    w_next_kill = 1'b1;
                end else begin
                    w_pc_sel = PC_HOLD;
                end
            end
            HOLD_S: begin
                if (redirect_i) begin
                    w_pc_sel     = PC_TARGET;
                    w_next_valid = 1'b0;
                    w_next_instr = NOP_WORD;
                    w_next_state = REQ_S;
                end else if (!stall_i) begin
                    w_pc_sel     = PC_INC;
                    w_next_valid = 1'b0;
                    w_next_instr = NOP_WORD;
                    w_next_state = REQ_S;
                end else begin
                    w_pc_sel = PC_HOLD;
                end
            end
            default: begin
                w_next_state = REQ_S;
                w_next_kill  = 1'b0;
                w_next_valid = 1'b0;
                w_next_instr = NOP_WORD;
            end
        endcase
    end

    // State, kill flag and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= REQ_S;
            r_kill  <= 1'b0;
            r_instr <= NOP_WORD;
            r_pc_o  <= RESET_PC;
            r_valid <= 1'b0;
            r_flush <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_kill  <= w_next_kill;
            r_instr <= w_next_instr;
            r_pc_o  <= w_next_pc_o;
            r_valid <= w_next_valid;
            r_flush <= redirect_i;
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = w_pc;
    assign instr_o       = r_instr;
    assign pc_o          = r_pc_o;
    assign instr_valid_o = r_valid;
    assign if_flush_o    = r_flush;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: hand-driven memory handshake with hand-computed expectations.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        if_flush_o;

    int n_checks;
    int n_errors;

    if_fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_valid_o (instr_valid_o),
        .if_flush_o    (if_flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From a REQ_S cycle at addr: grant, return word one cycle later, land in HOLD_S.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
        chk("req_high", {31'd0, imem_req_o}, 32'd1);
        chk("req_addr", imem_addr_o, addr);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        chk("wait_req_low", {31'd0, imem_req_o}, 32'd0);
        chk("wait_not_valid", {31'd0, instr_valid_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word;
        tick();
        imem_rvalid_i = 1'b0;
        chk("hold_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("hold_instr", instr_o, word);
        chk("hold_pc", pc_o, addr);
        chk("hold_req_low", {31'd0, imem_req_o}, 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc_o", pc_o, 32'h0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_flush", {31'd0, if_flush_o}, 32'd1);
        reset = 1'b0;
        #1;

        // 1) back-to-back fetches, no stall
        fetch(32'h0, 32'h1111_0000);
        tick();
        chk("t1_consumed_instr", instr_o, 32'h0);
        chk("t1_consumed_valid", {31'd0, instr_valid_o}, 32'd0);
        fetch(32'h4, 32'h1111_0004);
        tick();
        fetch(32'h8, 32'h8C01_0004);

        // 2) stall in HOLD_S for 4 cycles
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_stall_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("t2_stall_instr", instr_o, 32'h8C01_0004);
            chk("t2_stall_pc", pc_o, 32'h8);
            chk("t2_stall_req", {31'd0, imem_req_o}, 32'd0);
        end
        stall_i = 1'b0;
        tick();
        chk("t2_next_req", {31'd0, imem_req_o}, 32'd1);
        chk("t2_next_addr", imem_addr_o, 32'hC);

        // 3) redirect while waiting, word arrives next cycle and is dropped
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0040;
        tick();
        redirect_i = 1'b0;
        chk("t3_flush", {31'd0, if_flush_o}, 32'd1);
        chk("t3_wait_req", {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        chk("t3_flush_gone", {31'd0, if_flush_o}, 32'd0);
        chk("t3_killed_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t3_killed_instr", instr_o, 32'h0);
        fetch(32'h40, 32'h2222_0040);
        tick();

        // 4) gnt withheld 5 cycles, redirect at cycle 2
        chk("t4_c0_addr", imem_addr_o, 32'h44);
        tick();
        chk("t4_c1_addr", imem_addr_o, 32'h44);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        tick();
        redirect_i = 1'b0;
        chk("t4_c2_addr", imem_addr_o, 32'h100);
        chk("t4_c2_req", {31'd0, imem_req_o}, 32'd1);
        chk("t4_c2_flush", {31'd0, if_flush_o}, 32'd1);
        tick();
        tick();
        tick();
        chk("t4_c5_addr", imem_addr_o, 32'h100);
        fetch(32'h100, 32'h3333_0100);

        // 5) redirect and stall together in HOLD_S
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        tick();
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        chk("t5_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t5_instr", instr_o, 32'h0);
        chk("t5_flush", {31'd0, if_flush_o}, 32'd1);

        // redirect coincident with grant: in-flight word is killed
        chk("t5_req", {31'd0, imem_req_o}, 32'd1);
        chk("t5_addr", imem_addr_o, 32'h200);
        imem_gnt_i    = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        tick();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0200;
        tick();
        imem_rvalid_i = 1'b0;
        chk("kill_gnt_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("kill_gnt_addr", imem_addr_o, 32'h300);

        // 6) unaligned target near top of memory, wrap, then reset in WAIT_S
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0;
        fetch(32'hFFFF_FFFC, 32'h4444_FFFC);
        tick();
        chk("t6_wrap_addr", imem_addr_o, 32'h0);
        chk("t6_wrap_req", {31'd0, imem_req_o}, 32'd1);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        reset      = 1'b1;
        tick();
        chk("t6_rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("t6_rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t6_rst_instr", instr_o, 32'h0);
        chk("t6_rst_pc_o", pc_o, 32'h0);
        chk("t6_rst_flush", {31'd0, if_flush_o}, 32'd1);
        reset         = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0000;
        #1;
        chk("t6_post_req", {31'd0, imem_req_o}, 32'd1);
        tick();
        imem_rvalid_i = 1'b0;
        chk("t6_late_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t6_late_instr", instr_o, 32'h0);
        fetch(32'h0, 32'h5555_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
